// File: rtl/controller_scanner_m.sv
// controller_scanner_m
// Polls NUM_CONTROLLERS serial shift-register gamepads over a shared latch and
// shift clock. Publishes button snapshots, newly-pressed flags and a one-cycle
// completion strobe. Every output, including the divided shift clock, is a flop.
module controller_scanner_m #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_BUTTONS     = 8,
  parameter int HALF_PERIOD     = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_fetch,
  output logic                                 busy,
  output logic                                 controller_latch,
  output logic                                 controller_clk,
  input  logic [NUM_CONTROLLERS-1:0]           controller_data_B_LIST,
  output logic [NUM_BUTTONS*NUM_CONTROLLERS-1:0] controller_buttons_out_LIST,
  output logic [NUM_BUTTONS*NUM_CONTROLLERS-1:0] controller_pressed_LIST,
  output logic                                 sample_valid
);

  localparam int NC = NUM_CONTROLLERS;
  localparam int NB = NUM_BUTTONS;
  localparam int HP = HALF_PERIOD;
  localparam int PW = $clog2(HP * 2);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HP - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HP - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NB - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_BIT_LOW  = 3'd2,
    ST_BIT_HIGH = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t               state_r, state_next_s;
  logic [PW-1:0]        phase_r, phase_next_s;
  logic [BW-1:0]        bit_r, bit_next_s;
  logic                 shift_en_s;
  logic                 done_s;
  logic [NC-1:0]        sync1_r, sync2_r;
  logic [NB*NC-1:0]     shift_r;
  logic [NB*NC-1:0]     buttons_r, pressed_r;
  logic                 busy_r, latch_r, cclk_r, sample_valid_r;

  // Shift one new bit into the LSB; works for a single-bit register as well.
  function automatic logic [NB-1:0] shift_in(input logic [NB-1:0] old_val, input logic bit_val);
    logic [NB:0] tmp;
    tmp = {old_val, bit_val};
    return tmp[NB-1:0];
  endfunction

  // Next-state, phase/bit counter and strobe decode for the poll sequence.
  always_comb begin
    state_next_s = state_r;
    phase_next_s = phase_r + PW'(1);
    bit_next_s   = bit_r;
    shift_en_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        phase_next_s = {PW{1'b0}};
        if (start_fetch) begin
          state_next_s = ST_LATCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (phase_r == LATCH_LAST) begin
          state_next_s = ST_BIT_LOW;
          phase_next_s = {PW{1'b0}};
          bit_next_s   = {BW{1'b0}};
        end else begin
          state_next_s = ST_LATCH;
        end
      end
      ST_BIT_LOW: begin
        if (phase_r == HALF_LAST) begin
          // Data has been stable for a full high phase; capture it now.
          shift_en_s   = 1'b1;
          state_next_s = ST_BIT_HIGH;
          phase_next_s = {PW{1'b0}};
        end else begin
          state_next_s = ST_BIT_LOW;
        end
      end
      ST_BIT_HIGH: begin
        if (phase_r == HALF_LAST) begin
          phase_next_s = {PW{1'b0}};
          if (bit_r == BIT_LAST) begin
            state_next_s = ST_DONE;
          end else begin
            bit_next_s   = bit_r + BW'(1);
            state_next_s = ST_BIT_LOW;
          end
        end else begin
          state_next_s = ST_BIT_HIGH;
        end
      end
      ST_DONE: begin
        done_s       = 1'b1;
        phase_next_s = {PW{1'b0}};
        state_next_s = ST_IDLE;
      end
      default: begin
        phase_next_s = {PW{1'b0}};
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and pin outputs; pins are registered from the next state
  // so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      phase_r        <= {PW{1'b0}};
      bit_r          <= {BW{1'b0}};
      busy_r         <= 1'b0;
      latch_r        <= 1'b0;
      cclk_r         <= 1'b1;
      sample_valid_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      phase_r        <= phase_next_s;
      bit_r          <= bit_next_s;
      busy_r         <= (state_next_s != ST_IDLE);
      latch_r        <= (state_next_s == ST_LATCH);
      cclk_r         <= (state_next_s != ST_BIT_LOW);
      sample_valid_r <= done_s;
    end
  end

  // Two-flop synchronizer on the asynchronous pad data lines (idle level high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NC{1'b1}};
      sync2_r <= {NC{1'b1}};
    end else begin
      sync1_r <= controller_data_B_LIST;
      sync2_r <= sync1_r;
    end
  end

  // Per-pad shift registers; active-low data is inverted so 1 means pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {(NB*NC){1'b0}};
    end else if (shift_en_s) begin
      for (int c = 0; c < NC; c++) begin
        shift_r[NB*c +: NB] <= shift_in(shift_r[NB*c +: NB], ~sync2_r[c]);
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // Publish the snapshot and the 0->1 edge flags once per completed poll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons_r <= {(NB*NC){1'b0}};
      pressed_r <= {(NB*NC){1'b0}};
    end else if (done_s) begin
      buttons_r <= shift_r;
      pressed_r <= shift_r & ~buttons_r;
    end else begin
      buttons_r <= buttons_r;
      pressed_r <= pressed_r;
    end
  end

  assign busy                        = busy_r;
  assign controller_latch            = latch_r;
  assign controller_clk              = cclk_r;
  assign sample_valid                = sample_valid_r;
  assign controller_buttons_out_LIST = buttons_r;
  assign controller_pressed_LIST     = pressed_r;

endmodule
